// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment type, special segment codes and the BCD-to-segment decode
// shared by the scan driver and the standalone decoder.
package sevenseg_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;
    // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
    function automatic seg_t bcd_to_seg_code(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_DASH;
        endcase
    endfunction
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational 4-bit BCD to active-low seven-segment decoder.
module bcd_to_seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);
    assign seg = bcd_to_seg_code(bcd);
endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed common-anode display driver with a shadow
// register, leading-zero blanking and a frame-complete pulse.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    typedef enum logic {OFF, SCAN} state_t;
    state_t                  state, state_next;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx, idx_next;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   nz;
    logic                    above, tick, blank, fd_next;
    logic [3:0]              nibble;
    seg_t                    code;
    assign tick     = presc == PW'(REFRESH_DIV - 1);
    assign idx_next = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    assign nibble   = shadow[4*idx_next +: 4];
    // nz[i] is set when digit i or any digit above it is nonzero (dash codes count).
    always_comb begin
        nz    = '0;
        above = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            above = above | (shadow[4*k +: 4] != 4'd0);
            nz[k] = above;
        end
    end
    assign blank = blank_lz && idx_next != '0 && !nz[idx_next];
    bcd_to_seg u_dec (.bcd(nibble), .seg(code));
    always_comb begin
        state_next = tick ? SCAN : state;
        fd_next    = tick && state == SCAN && idx == IW'(NUM_DIGITS - 1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= OFF;
            presc      <= '0;
            idx        <= IW'(NUM_DIGITS - 1);
            shadow     <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            presc      <= tick ? '0 : presc + 1'b1;
            frame_done <= fd_next;
            if (load) shadow <= bcd_in;
            if (tick) begin
                idx <= idx_next;
                an  <= ~(NUM_DIGITS'(1) << idx_next);
                seg <= blank ? SEG_BLANK : code;
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: directed scenarios checked against a slot-arithmetic
// model every cycle, plus literal expectations for each scenario.
module tb_sevenseg_scan_driver;
    localparam int N = 4;
    localparam int R = 4;
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    logic          clk = 0, reset = 1, load = 0, blank_lz = 0;
    logic [15:0]   bcd_in = '0;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          frame_done;
    int            checks = 0, failures = 0;
    int            e;
    logic [15:0]   sh_m;
    logic [3:0]    m_an;
    logic [6:0]    m_seg;
    logic          m_fd;

    sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int d, input logic bl);
        logic [15:0] up;
        up = sh >> (4 * d);
        if (bl && d > 0 && up == 0) return 7'h7F;
        return DEC[up[3:0]];
    endfunction

    // Edge e (1-based since release) is a tick when e % R == 0; slot s = e/R - 1 shows digit s % N.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e     <= 0;
            sh_m  <= '0;
            m_an  <= 4'hF;
            m_seg <= 7'h7F;
            m_fd  <= 1'b0;
        end else begin
            e    <= e + 1;
            m_fd <= 1'b0;
            if (load) sh_m <= bcd_in;
            if ((e + 1) % R == 0) begin
                m_an  <= ~(4'b1 << (((e + 1) / R - 1) % N));
                m_seg <= exp_seg(sh_m, ((e + 1) / R - 1) % N, blank_lz);
                m_fd  <= (((e + 1) / R - 1) % N == 0) && (e + 1 > R);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_an", an, m_an);
        chk("model_seg", seg, m_seg);
        chk("model_fd", frame_done, m_fd);
    end

    task automatic wait_an(input logic [3:0] t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== t && n < 40);
        chk("wait_an", an, t);
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 80);
        chk("wait_fd", frame_done, 1);
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1;
        @(negedge clk);
        load = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_fd", frame_done, 0);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("pre_tick_an", an, 4'hF);
        @(negedge clk);
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 7'h40);
        // asynchronous reset between edges, in the middle of a slot
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_seg", seg, 7'h7F);
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("rerst_off_an", an, 4'hF);
        @(negedge clk);
        chk("rerst_an", an, 4'b1110);
        // normal scan
        do_load(16'h1234);
        wait_fd();
        chk("scan0_an", an, 4'b1110);
        chk("scan0_seg", seg, 7'h19);
        wait_an(4'b1101);
        chk("scan1_seg", seg, 7'h30);
        begin
            int hold = 0;
            while (an == 4'b1101 && hold < 10) begin
                hold++;
                @(negedge clk);
            end
            chk("slot_len", hold, 4);
        end
        chk("scan2_an", an, 4'b1011);
        chk("scan2_seg", seg, 7'h24);
        wait_an(4'b0111);
        chk("scan3_seg", seg, 7'h79);
        // leading-zero blanking
        blank_lz = 1;
        do_load(16'h0007);
        wait_fd();
        chk("lz7_d0", seg, 7'h78);
        wait_an(4'b1101);
        chk("lz7_d1", seg, 7'h7F);
        wait_an(4'b0111);
        chk("lz7_d3", seg, 7'h7F);
        do_load(16'h0000);
        wait_fd();
        chk("lz0_d0", seg, 7'h40);
        wait_an(4'b1011);
        chk("lz0_d2", seg, 7'h7F);
        // invalid code
        do_load(16'h00A0);
        wait_fd();
        chk("inv_d0", seg, 7'h40);
        wait_an(4'b1101);
        chk("inv_d1", seg, 7'h3F);
        wait_an(4'b1011);
        chk("inv_d2", seg, 7'h7F);
        wait_an(4'b0111);
        chk("inv_d3", seg, 7'h7F);
        // load coincident with tick
        blank_lz = 0;
        do_load(16'h1111);
        wait_fd();
        repeat (3) @(negedge clk);
        bcd_in = 16'h2222;
        load   = 1;
        @(negedge clk);
        load = 0;
        chk("coin_an", an, 4'b1101);
        chk("coin_seg", seg, 7'h79);
        wait_an(4'b1011);
        chk("coin_next_seg", seg, 7'h24);
        repeat (2 * N * R) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Time-multiplexed seven-segment display driver that sits directly downstream of the BCD counter chain. It captures a packed vector of BCD digits on a load strobe and scans them onto a common-anode display, one digit per refresh slot. It provides leading-zero blanking, a dash for invalid codes, and a frame-complete pulse.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-high.
- `bcd_in`, input, 4*NUM_DIGITS: packed digits; nibble i is digit i, and digit 0 is the least significant.
- `load`, input, 1: captures `bcd_in` into the shadow register at the clock edge where it is high.
- `blank_lz`, input, 1: enables leading-zero blanking; sampled live.
- `seg`, output, 7: active-low segments `{g,f,e,d,c,b,a}`.
- `an`, output, NUM_DIGITS: active-low digit enables; at most one bit is low.
- `frame_done`, output, 1: one-cycle pulse when a full scan frame completes.

## Operation
- **Shadow register:** NUM_DIGITS×4 bits. It is written only on `load`, which keeps the display glitch-free while upstream counts.
- **Prescaler:** counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when the prescaler equals REFRESH_DIV-1.
- **Digit index:** held in register `idx`.
  - Reset value is NUM_DIGITS-1.
  - On `tick`, `idx` advances to `(idx+1) mod NUM_DIGITS`.
- **Output registers:** on `tick`, `an` and `seg` are loaded from the new `idx`.
  - `an` = all ones with bit `idx` cleared.
  - `seg` = decode of shadow nibble `idx`.
- **Decode** (active-low hex values):
  - 0 → 0x40, 1 → 0x79, 2 → 0x24, 3 → 0x30, 4 → 0x19
  - 5 → 0x12, 6 → 0x02, 7 → 0x78, 8 → 0x00, 9 → 0x10
  - 10–15 (invalid) → dash, 0x3F
  - blank → 0x7F
- **Leading-zero blanking:** when `blank_lz` = 1, digit i shows blank if it and every digit above it are 0.
  - Invalid codes count as nonzero.
  - Digit 0 is never blanked.
- **State machine:** two states.
  - OFF (after reset): `an` = all ones, `seg` = 0x7F.
  - OFF → SCAN on the first `tick`.
  - SCAN stays in SCAN until reset.
- **`frame_done`:** registered pulse on a `tick` where `idx` = NUM_DIGITS-1 and the state is SCAN. It does not fire on the first tick after reset.

## Timing
- **Reset values:**
  - `an` = all ones, `seg` = 0x7F, `frame_done` = 0.
  - Prescaler = 0, `idx` = NUM_DIGITS-1, shadow = 0, state = OFF.
  - Reset takes effect immediately, without a clock edge, including mid-slot; scanning restarts from OFF.
- **First display:** `an`/`seg` first change at clock edge REFRESH_DIV after reset release, showing digit 0.
- **Slot timing:** each digit is held exactly REFRESH_DIV cycles. One full frame is NUM_DIGITS×REFRESH_DIV cycles.
- **Load latency:** a new shadow value is first visible at the next `tick` after the capture edge.
- **`load` coincident with `tick`:** the slot starting at that edge uses the old shadow value; the new value appears from the following slot.
- **`blank_lz` changes:** take effect at the next `tick`.
- **`frame_done` timing:** high for one cycle, coincident with the edge at which digit 0 is redriven.

## Structure
- **Package `sevenseg_pkg`:**
  - Constants `SEG_BLANK` (7'h7F) and `SEG_DASH` (7'h3F).
  - The 7-bit segment type.
  - Function `bcd_to_seg_code` containing the decode listed above.
- **Sub-module `bcd_to_seg`:** purely combinational, 4-bit in, 7-bit out; wraps the package function and is also usable standalone.
- **Top level:** holds the shadow register, prescaler (width `$clog2(REFRESH_DIV)`), `idx`, the leading-zero mask logic (a NUM_DIGITS-bit "any nonzero at or above" chain), and the output registers.

## Test plan
All scenarios use NUM_DIGITS = 4 and REFRESH_DIV = 4.
- **Asynchronous reset mid-slot:** assert `reset` between clock edges → `an` = 4'b1111 and `seg` = 0x7F immediately; first digit reappears 4 edges after release.
- **Normal scan:** load 16'h1234, `blank_lz` = 0 → successive slots show:
  - `an` = 1110 with `seg` = 0x19
  - `an` = 1101 with `seg` = 0x30
  - `an` = 1011 with `seg` = 0x24
  - `an` = 0111 with `seg` = 0x79
  - Each slot lasts 4 cycles; `frame_done` pulses once when `an` returns to 1110.
- **Leading-zero blanking:** `blank_lz` = 1, load 16'h0007 → digits 3..1 show 0x7F and digit 0 shows 0x78. Then load 16'h0000 → digit 0 shows 0x40 and the rest show 0x7F.
- **Invalid code:** load 16'h00A0 with `blank_lz` = 1 → digit 1 shows 0x3F, digit 0 shows 0x40, digits 3..2 show 0x7F.
- **`load` coincident with `tick`:** shadow 16'h1111, load 16'h2222 on a tick edge → that slot shows 0x79 and the next slot shows 0x24.
